// File: rtl/ctrl_pipe_hazard.sv
// Control pipeline (ID/EX, EX/MEM, MEM/WB) for the 5-stage MIPS core, with
// load-use stall, taken-branch squash, EX operand forwarding and event counters.
module ctrl_pipe_hazard (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_valid,
  input  logic        id_RegWrite,
  input  logic        id_MemtoReg,
  input  logic        id_MemWrite,
  input  logic        id_Branch,
  input  logic        id_ALUSrc,
  input  logic        id_ALUSrc_shamt,
  input  logic        id_RegDst,
  input  logic [3:0]  id_ALUControl,
  input  logic [4:0]  id_rs,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic        ex_branch_taken,
  output logic        stall_f_d,
  output logic        flush_d,
  output logic        ex_valid,
  output logic        ex_RegWrite,
  output logic        ex_MemtoReg,
  output logic        ex_MemWrite,
  output logic        ex_Branch,
  output logic        ex_ALUSrc,
  output logic        ex_ALUSrc_shamt,
  output logic [3:0]  ex_ALUControl,
  output logic [4:0]  ex_rs,
  output logic [4:0]  ex_rt,
  output logic [4:0]  ex_wreg,
  output logic        mem_RegWrite,
  output logic        mem_MemtoReg,
  output logic        mem_MemWrite,
  output logic [4:0]  mem_wreg,
  output logic        wb_RegWrite,
  output logic        wb_MemtoReg,
  output logic [4:0]  wb_wreg,
  output logic [1:0]  fwd_a,
  output logic [1:0]  fwd_b,
  output logic [15:0] stall_cnt,
  output logic [15:0] flush_cnt
);

  logic [4:0] id_wreg;
  logic       id_rw;
  logic       uses_rs;
  logic       uses_rt;
  logic       load_use;
  logic       branch_taken;
  logic       bubble;

  always_comb begin
    id_wreg      = id_RegDst ? id_rd : id_rt;
    // $0 is never a write target, so it can never match a forwarding compare
    id_rw        = id_RegWrite & id_valid & (id_wreg != '0);
    uses_rs      = ~id_ALUSrc_shamt;
    uses_rt      = ~id_ALUSrc | id_MemWrite | id_ALUSrc_shamt;
    load_use     = ex_valid & ex_MemtoReg & ex_RegWrite & id_valid &
                   ((uses_rs & (ex_wreg == id_rs)) | (uses_rt & (ex_wreg == id_rt)));
    branch_taken = ex_valid & ex_Branch & ex_branch_taken;
    flush_d      = branch_taken;
    stall_f_d    = load_use & ~branch_taken;
    bubble       = flush_d | stall_f_d;
  end

  always_comb begin
    fwd_a = 2'b00;
    fwd_b = 2'b00;
    if (mem_RegWrite && (mem_wreg == ex_rs))     fwd_a = 2'b10;
    else if (wb_RegWrite && (wb_wreg == ex_rs))  fwd_a = 2'b01;
    if (mem_RegWrite && (mem_wreg == ex_rt))     fwd_b = 2'b10;
    else if (wb_RegWrite && (wb_wreg == ex_rt))  fwd_b = 2'b01;
  end

  // ID/EX: bubble clears control and register fields alike
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid        <= 1'b0;
      ex_RegWrite     <= 1'b0;
      ex_MemtoReg     <= 1'b0;
      ex_MemWrite     <= 1'b0;
      ex_Branch       <= 1'b0;
      ex_ALUSrc       <= 1'b0;
      ex_ALUSrc_shamt <= 1'b0;
      ex_ALUControl   <= '0;
      ex_rs           <= '0;
      ex_rt           <= '0;
      ex_wreg         <= '0;
    end else if (bubble) begin
      ex_valid        <= 1'b0;
      ex_RegWrite     <= 1'b0;
      ex_MemtoReg     <= 1'b0;
      ex_MemWrite     <= 1'b0;
      ex_Branch       <= 1'b0;
      ex_ALUSrc       <= 1'b0;
      ex_ALUSrc_shamt <= 1'b0;
      ex_ALUControl   <= '0;
      ex_rs           <= '0;
      ex_rt           <= '0;
      ex_wreg         <= '0;
    end else begin
      ex_valid        <= id_valid;
      ex_RegWrite     <= id_rw;
      ex_MemtoReg     <= id_MemtoReg & id_valid;
      ex_MemWrite     <= id_MemWrite & id_valid;
      ex_Branch       <= id_Branch & id_valid;
      ex_ALUSrc       <= id_ALUSrc & id_valid;
      ex_ALUSrc_shamt <= id_ALUSrc_shamt & id_valid;
      ex_ALUControl   <= id_valid ? id_ALUControl : '0;
      ex_rs           <= id_rs;
      ex_rt           <= id_rt;
      ex_wreg         <= id_wreg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_RegWrite <= 1'b0;
      mem_MemtoReg <= 1'b0;
      mem_MemWrite <= 1'b0;
      mem_wreg     <= '0;
      wb_RegWrite  <= 1'b0;
      wb_MemtoReg  <= 1'b0;
      wb_wreg      <= '0;
    end else begin
      mem_RegWrite <= ex_valid & ex_RegWrite;
      mem_MemtoReg <= ex_valid & ex_MemtoReg;
      mem_MemWrite <= ex_valid & ex_MemWrite;
      mem_wreg     <= ex_wreg;
      wb_RegWrite  <= mem_RegWrite;
      wb_MemtoReg  <= mem_MemtoReg;
      wb_wreg      <= mem_wreg;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall_f_d && (stall_cnt != '1)) stall_cnt <= stall_cnt + 16'd1;
      if (flush_d && (flush_cnt != '1))   flush_cnt <= flush_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_hazard.sv
// Directed bench for ctrl_pipe_hazard: forwarding, load-use stall, branch
// squash, mid-stream reset and counter saturation with hand-computed values.
module tb_ctrl_pipe_hazard;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid, id_RegWrite, id_MemtoReg, id_MemWrite, id_Branch;
  logic        id_ALUSrc, id_ALUSrc_shamt, id_RegDst;
  logic [3:0]  id_ALUControl;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        ex_branch_taken;
  logic        stall_f_d, flush_d;
  logic        ex_valid, ex_RegWrite, ex_MemtoReg, ex_MemWrite, ex_Branch;
  logic        ex_ALUSrc, ex_ALUSrc_shamt;
  logic [3:0]  ex_ALUControl;
  logic [4:0]  ex_rs, ex_rt, ex_wreg;
  logic        mem_RegWrite, mem_MemtoReg, mem_MemWrite;
  logic [4:0]  mem_wreg;
  logic        wb_RegWrite, wb_MemtoReg;
  logic [4:0]  wb_wreg;
  logic [1:0]  fwd_a, fwd_b;
  logic [15:0] stall_cnt, flush_cnt;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  ctrl_pipe_hazard dut (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_RegWrite(id_RegWrite), .id_MemtoReg(id_MemtoReg), .id_MemWrite(id_MemWrite),
    .id_Branch(id_Branch), .id_ALUSrc(id_ALUSrc), .id_ALUSrc_shamt(id_ALUSrc_shamt),
    .id_RegDst(id_RegDst), .id_ALUControl(id_ALUControl),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .ex_branch_taken(ex_branch_taken),
    .stall_f_d(stall_f_d), .flush_d(flush_d),
    .ex_valid(ex_valid), .ex_RegWrite(ex_RegWrite), .ex_MemtoReg(ex_MemtoReg),
    .ex_MemWrite(ex_MemWrite), .ex_Branch(ex_Branch), .ex_ALUSrc(ex_ALUSrc),
    .ex_ALUSrc_shamt(ex_ALUSrc_shamt), .ex_ALUControl(ex_ALUControl),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_wreg(ex_wreg),
    .mem_RegWrite(mem_RegWrite), .mem_MemtoReg(mem_MemtoReg), .mem_MemWrite(mem_MemWrite),
    .mem_wreg(mem_wreg), .wb_RegWrite(wb_RegWrite), .wb_MemtoReg(wb_MemtoReg),
    .wb_wreg(wb_wreg), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_nop();
    id_valid = 1'b0; id_RegWrite = 1'b0; id_MemtoReg = 1'b0; id_MemWrite = 1'b0;
    id_Branch = 1'b0; id_ALUSrc = 1'b0; id_ALUSrc_shamt = 1'b0; id_RegDst = 1'b0;
    id_ALUControl = '0; id_rs = '0; id_rt = '0; id_rd = '0;
  endtask

  task automatic id_instr(input logic rw, input logic mtr, input logic mw, input logic br,
                          input logic alusrc, input logic shamt, input logic regdst,
                          input logic [3:0] aluc, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd);
    id_valid = 1'b1; id_RegWrite = rw; id_MemtoReg = mtr; id_MemWrite = mw;
    id_Branch = br; id_ALUSrc = alusrc; id_ALUSrc_shamt = shamt; id_RegDst = regdst;
    id_ALUControl = aluc; id_rs = rs; id_rt = rt; id_rd = rd;
  endtask

  // R-type ALU op writing rd
  task automatic id_rtype(input logic [3:0] aluc, input logic [4:0] rs,
                          input logic [4:0] rt, input logic [4:0] rd);
    id_instr(1, 0, 0, 0, 0, 0, 1, aluc, rs, rt, rd);
  endtask

  // lw rt, imm(rs)
  task automatic id_lw(input logic [4:0] rs, input logic [4:0] rt);
    id_instr(1, 1, 0, 0, 1, 0, 0, 4'd2, rs, rt, 5'd0);
  endtask

  logic [15:0] sat_exp [3];

  initial begin
    reset = 1'b1;
    ex_branch_taken = 1'b0;
    id_nop();
    #1;
    chk("rst_ex_valid", {15'd0, ex_valid}, 16'd0);
    chk("rst_stall", {15'd0, stall_f_d}, 16'd0);
    chk("rst_flush", {15'd0, flush_d}, 16'd0);
    chk("rst_fwd", {12'd0, fwd_a, fwd_b}, 16'd0);
    chk("rst_stall_cnt", stall_cnt, 16'd0);
    chk("rst_flush_cnt", flush_cnt, 16'd0);
    @(negedge clk);
    reset = 1'b0;

    // EX-to-EX forward: add $3,$1,$2 ; sub $4,$3,$3
    id_rtype(4'd2, 5'd1, 5'd2, 5'd3);
    tick();
    chk("add_ex_valid", {15'd0, ex_valid}, 16'd1);
    chk("add_ex_wreg", {11'd0, ex_wreg}, 16'd3);
    chk("add_ex_aluc", {12'd0, ex_ALUControl}, 16'd2);
    chk("add_ex_rw", {15'd0, ex_RegWrite}, 16'd1);
    id_rtype(4'd6, 5'd3, 5'd3, 5'd4);
    tick();
    chk("add_mem_rw", {15'd0, mem_RegWrite}, 16'd1);
    chk("add_mem_wreg", {11'd0, mem_wreg}, 16'd3);
    chk("exex_fwd_a", {14'd0, fwd_a}, 16'h2);
    chk("exex_fwd_b", {14'd0, fwd_b}, 16'h2);
    id_nop();
    tick();
    chk("add_wb_rw", {15'd0, wb_RegWrite}, 16'd1);
    chk("add_wb_wreg", {11'd0, wb_wreg}, 16'd3);
    chk("nop_ex_valid", {15'd0, ex_valid}, 16'd0);

    // Double hazard: add $5 ; or $5 ; and $7,$5,$6 ; xor $10,$9,$5
    id_rtype(4'd2, 5'd1, 5'd2, 5'd5);
    tick();
    id_rtype(4'd1, 5'd1, 5'd2, 5'd5);
    tick();
    id_rtype(4'd0, 5'd5, 5'd6, 5'd7);
    tick();
    chk("dbl_fwd_a_mem_prio", {14'd0, fwd_a}, 16'h2);
    chk("dbl_fwd_b_none", {14'd0, fwd_b}, 16'h0);
    id_rtype(4'd3, 5'd9, 5'd5, 5'd10);
    tick();
    chk("wb_fwd_a_none", {14'd0, fwd_a}, 16'h0);
    chk("wb_fwd_b", {14'd0, fwd_b}, 16'h1);

    // Write to $0 is suppressed
    id_rtype(4'd2, 5'd1, 5'd2, 5'd0);
    tick();
    chk("r0_ex_rw", {15'd0, ex_RegWrite}, 16'd0);
    id_rtype(4'd2, 5'd0, 5'd0, 5'd11);
    tick();
    chk("r0_mem_rw", {15'd0, mem_RegWrite}, 16'd0);
    chk("r0_fwd", {12'd0, fwd_a, fwd_b}, 16'd0);

    // Load-use: lw $8 ; add $12,$8,$9
    id_lw(5'd29, 5'd8);
    tick();
    id_rtype(4'd2, 5'd8, 5'd9, 5'd12);
    #1;
    chk("lu_stall", {15'd0, stall_f_d}, 16'd1);
    chk("lu_flush", {15'd0, flush_d}, 16'd0);
    tick();
    chk("lu_bubble", {15'd0, ex_valid}, 16'd0);
    chk("lu_stall_cnt", stall_cnt, 16'd1);
    chk("lu_stall_once", {15'd0, stall_f_d}, 16'd0);
    tick();
    chk("lu_add_ex", {15'd0, ex_valid}, 16'd1);
    chk("lu_fwd_a", {14'd0, fwd_a}, 16'h1);
    chk("lu_fwd_b", {14'd0, fwd_b}, 16'h0);
    chk("lu_stall_cnt_hold", stall_cnt, 16'd1);

    // lw $8 followed by addi $8,$3,imm: rt is a destination, not a source
    id_lw(5'd29, 5'd8);
    tick();
    id_instr(1, 0, 0, 0, 1, 0, 0, 4'd2, 5'd3, 5'd8, 5'd0);
    #1;
    chk("addi_no_stall", {15'd0, stall_f_d}, 16'd0);
    tick();

    // Taken branch with a simultaneous load-use condition in ID
    id_instr(1, 1, 0, 1, 0, 0, 0, 4'd6, 5'd1, 5'd8, 5'd0);
    tick();
    id_rtype(4'd2, 5'd8, 5'd9, 5'd12);
    ex_branch_taken = 1'b1;
    #1;
    chk("br_flush", {15'd0, flush_d}, 16'd1);
    chk("br_stall_override", {15'd0, stall_f_d}, 16'd0);
    tick();
    chk("br_bubble", {15'd0, ex_valid}, 16'd0);
    chk("br_flush_cnt", flush_cnt, 16'd1);
    chk("br_stall_cnt", stall_cnt, 16'd1);
    chk("br_taken_ignored", {15'd0, flush_d}, 16'd0);
    ex_branch_taken = 1'b0;

    // Reset with three valid instructions in flight
    id_rtype(4'd2, 5'd1, 5'd2, 5'd13);
    tick();
    id_rtype(4'd2, 5'd1, 5'd2, 5'd14);
    tick();
    id_rtype(4'd2, 5'd1, 5'd2, 5'd15);
    tick();
    chk("inflight_wb", {15'd0, wb_RegWrite}, 16'd1);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("mrst_ex_valid", {15'd0, ex_valid}, 16'd0);
    chk("mrst_ex_wreg", {11'd0, ex_wreg}, 16'd0);
    chk("mrst_mem", {10'd0, mem_RegWrite, mem_wreg}, 16'd0);
    chk("mrst_wb", {10'd0, wb_RegWrite, wb_wreg}, 16'd0);
    chk("mrst_stall_cnt", stall_cnt, 16'd0);
    chk("mrst_flush_cnt", flush_cnt, 16'd0);
    @(negedge clk);
    reset = 1'b0;
    id_rtype(4'd2, 5'd1, 5'd2, 5'd16);
    tick();
    chk("post_rst_ex_valid", {15'd0, ex_valid}, 16'd1);
    chk("post_rst_ex_wreg", {11'd0, ex_wreg}, 16'd16);

    // Saturation: start the counter just below the ceiling, then stall three times
    force dut.stall_cnt = 16'hFFFD;
    #1;
    release dut.stall_cnt;
    sat_exp[0] = 16'hFFFE;
    sat_exp[1] = 16'hFFFF;
    sat_exp[2] = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      id_lw(5'd29, 5'd8);
      tick();
      id_rtype(4'd2, 5'd8, 5'd9, 5'd12);
      #1;
      chk("sat_stall", {15'd0, stall_f_d}, 16'd1);
      tick();
      chk("sat_stall_cnt", stall_cnt, sat_exp[i]);
    end
    chk("sat_flush_cnt", flush_cnt, 16'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
